regfile_core: RTL and testbench

- 32 x 32-bit general-purpose register array, with one write port and two registered read ports (A and B).
- Directly upstream of the 32:1 read-select mux (mux_32): the array drives all 32 register values into one mux_32 instance per read port.
- Each port's mux output is captured in a read-data register, so read data is presented one cycle after the request.
- Sits between the decode stage (read addresses) and the writeback stage (write port) of the processor.

---
 rtl/regfile_core.sv | 137 +++++++++++++
 tb/tb_regfile_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_core (with helper mux_32)                          |
// | Description : 32 x 32-bit register file, one write port and two          |
// |               registered read ports with single-cycle read latency.      |
// |               Optional macro REGFILE_BYPASS_EN adds write-to-read        |
// |               forwarding on same-edge index matches.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// 32:1 word select used once per read port.
module mux_32 #(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       sel_i,
  input  logic [WIDTH-1:0] data_i [32],
  output logic [WIDTH-1:0] data_o
);

  assign data_o = data_i[sel_i];

endmodule

module regfile_core #(
  parameter bit          ZERO_REG    = 1'b1,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic        ctrl_readEn,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB,
  output logic        data_readValid
);

  // Storage outputs fanned into both read muxes.
  logic [31:0] regs_w [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0 && ZERO_REG) begin : g_zero
        // Hardwired zero: no flop, writes to index 0 simply have no target.
        assign regs_w[gi] = 32'h0000_0000;
      end else begin : g_store
        logic [31:0] reg_q;
        logic [31:0] reg_d;

        assign reg_d = (ctrl_writeEnable && (ctrl_writeReg == 5'(gi)))
                       ? data_writeReg : reg_q;

        // Storage register: loads write data when addressed by the write port.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) reg_q <= RESET_VALUE;
          else          reg_q <= reg_d;
        end

        assign regs_w[gi] = reg_q;
      end
    end
  endgenerate

  logic [31:0] mux_a;
  logic [31:0] mux_b;

  mux_32 #(.WIDTH(32)) u_mux_a (
    .sel_i  (ctrl_readRegA),
    .data_i (regs_w),
    .data_o (mux_a)
  );

  mux_32 #(.WIDTH(32)) u_mux_b (
    .sel_i  (ctrl_readRegB),
    .data_i (regs_w),
    .data_o (mux_b)
  );

  // Value each port would capture this edge.
  logic [31:0] sel_a;
  logic [31:0] sel_b;

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write so a same-edge read sees the new value;
  // a hardwired zero register is never forwarded.
  logic fwd_a;
  logic fwd_b;
  assign fwd_a = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) &&
                 ((ctrl_readRegA != 5'd0) || !ZERO_REG);
  assign fwd_b = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) &&
                 ((ctrl_readRegB != 5'd0) || !ZERO_REG);
  assign sel_a = fwd_a ? data_writeReg : mux_a;
  assign sel_b = fwd_b ? data_writeReg : mux_b;
`else
  // Reads see pre-write contents on a same-edge collision.
  assign sel_a = mux_a;
  assign sel_b = mux_b;
`endif

  logic [31:0] rd_a_q, rd_a_d;
  logic [31:0] rd_b_q, rd_b_d;
  logic        valid_q, valid_d;

  // Next read-data state: capture on request, otherwise hold; valid tracks request.
  always_comb begin
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    valid_d = ctrl_readEn;
    if (ctrl_readEn) begin
      rd_a_d = sel_a;
      rd_b_d = sel_b;
    end
  end

  // Read-data registers; reset clears data and drops valid immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q  <= 32'h0000_0000;
      rd_b_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      valid_q <= valid_d;
    end
  end

  assign data_readRegA  = rd_a_q;
  assign data_readRegB  = rd_b_q;
  assign data_readValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_core.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_core                                            |
// | Description : Scoreboard bench for regfile_core. Two instances share     |
// |               stimulus: one with a hardwired zero register and zero      |
// |               reset value, one with an ordinary r0 and non-zero reset.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_core;

  localparam logic [31:0] RV1 = 32'hA5A5_0F0F;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        ctrl_readEn;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        vld0, vld1;

  regfile_core #(.ZERO_REG(1'b1), .RESET_VALUE(32'h0000_0000)) u_dut0 (
    .clock            (clock),
    .reset_n          (reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readEn      (ctrl_readEn),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (rd_a0),
    .data_readRegB    (rd_b0),
    .data_readValid   (vld0)
  );

  regfile_core #(.ZERO_REG(1'b0), .RESET_VALUE(RV1)) u_dut1 (
    .clock            (clock),
    .reset_n          (reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readEn      (ctrl_readEn),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (rd_a1),
    .data_readRegB    (rd_b1),
    .data_readValid   (vld1)
  );

  always #5 clock = ~clock;

  int unsigned edge_cnt = 0;
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  typedef struct {
    int unsigned edge_no;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
  } exp_t;

  exp_t sbq[$];

  // Reference model: plain register arrays, one per instance.
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 32'h0000_0000;
      mem1[i] = RV1;
    end
  endtask

  // Expected captured value for one instance and one read port.
  function automatic logic [31:0] mdl_read(input int d, input logic [4:0] idx,
                                           input bit we, input logic [4:0] wr,
                                           input logic [31:0] wd);
    if (d == 0 && idx == 5'd0) return 32'h0000_0000;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return (d == 0) ? mem0[idx] : mem1[idx];
  endfunction

  // Drive one cycle's inputs and record what the scoreboard should see.
  task automatic issue(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input bit re, input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readEn      = re;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    if (re) begin
      e.edge_no = edge_cnt + 1;
      e.a0 = mdl_read(0, ra, we, wr, wd);
      e.b0 = mdl_read(0, rb, we, wr, wd);
      e.a1 = mdl_read(1, ra, we, wr, wd);
      e.b1 = mdl_read(1, rb, we, wr, wd);
      sbq.push_back(e);
    end
    if (we) begin
      if (wr != 5'd0) mem0[wr] = wd;
      mem1[wr] = wd;
    end
  endtask

  task automatic step(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                      input bit re, input logic [4:0] ra, input logic [4:0] rb);
    issue(we, wr, wd, re, ra, rb);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  // Monitor: checks presented results against the scoreboard, holds when idle,
  // and zero outputs while reset is asserted.
  logic [31:0] last_a0 = '0, last_b0 = '0, last_a1 = '0, last_b1 = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or negedge reset_n);
      #1;
      chk("valid_agree", {31'b0, vld1}, {31'b0, vld0});
      if (!reset_n) begin
        chk("rst_valid", {31'b0, vld0}, 32'h0);
        chk("rst_a0", rd_a0, 32'h0);
        chk("rst_b0", rd_b0, 32'h0);
        chk("rst_a1", rd_a1, 32'h0);
        chk("rst_b1", rd_b1, 32'h0);
        sbq.delete();
        last_a0 = '0; last_b0 = '0; last_a1 = '0; last_b1 = '0;
      end else if (vld0) begin
        if (sbq.size() == 0 || sbq[0].edge_no != edge_cnt) begin
          chk("spurious_valid", {31'b0, vld0}, 32'h0);
          last_a0 = rd_a0; last_b0 = rd_b0; last_a1 = rd_a1; last_b1 = rd_b1;
        end else begin
          e = sbq.pop_front();
          chk("rd_a_zr1", rd_a0, e.a0);
          chk("rd_b_zr1", rd_b0, e.b0);
          chk("rd_a_zr0", rd_a1, e.a1);
          chk("rd_b_zr0", rd_b1, e.b1);
          last_a0 = e.a0; last_b0 = e.b0; last_a1 = e.a1; last_b1 = e.b1;
        end
      end else begin
        chk("hold_a_zr1", rd_a0, last_a0);
        chk("hold_b_zr1", rd_b0, last_b0);
        chk("hold_a_zr0", rd_a1, last_a1);
        chk("hold_b_zr0", rd_b1, last_b1);
        if (sbq.size() != 0 && sbq[0].edge_no <= edge_cnt) begin
          chk("missing_valid", {31'b0, vld0}, 32'h1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readEn      = 1'b0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    reset_n          = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Post-reset reads, write-then-read, zero register, same-edge collision.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd31);
    step(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h2222_2222, 1'b1, 5'd3, 5'd3);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    step(1'b1, 5'd0, 32'hCAFE_0000, 1'b1, 5'd0, 5'd0);

    // Streaming sweep, then idle to observe hold.
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
    repeat (3) idle();

    // Random traffic with a narrowed index range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr, ra, rb;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rb = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wr, $urandom, ($urandom_range(0, 3) != 0), ra, rb);
    end
    repeat (2) idle();

    // Reset in the middle of a read stream: in-flight request is lost.
    for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
    issue(1'b1, 5'd9, 32'h7777_7777, 1'b1, 5'd10, 5'd21);
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    ctrl_readEn = 1'b0;
    ctrl_writeEnable = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
